// File: rtl/sipo_rx_ctrl.sv
// Frame controller for an MSB-first SIPO: drives shift/clear, counts bits, holds words on valid/ready.
// Optional stalled-word watchdog is built when SIPO_RX_CTRL_TIMEOUT_EN is defined.
module sipo_rx_ctrl #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cs_n,
    input  logic                        bit_stb,
    output logic                        sr_sh,
    output logic                        sr_clr_n,
    input  logic [DATA_WIDTH-1:0]       sr_q,
    output logic [DATA_WIDTH-1:0]       m_data,
    output logic                        m_valid,
    input  logic                        m_ready,
    input  logic                        err_clr,
    output logic                        overrun,
    output logic                        frame_err,
    output logic [$clog2(DATA_WIDTH):0] bit_cnt
);
    localparam int unsigned CntW = $clog2(DATA_WIDTH) + 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(DATA_WIDTH - 1);

    typedef enum logic {StIdle, StShift} state_e;

    state_e                  state_q, state_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic                    capture_pend_q, capture_pend_d;
    logic [DATA_WIDTH-1:0]   m_data_q, m_data_d;
    logic                    m_valid_q, m_valid_d;
    logic                    overrun_q, overrun_d;
    logic                    frame_err_q, frame_err_d;
    logic                    sr_clr_n_q, sr_clr_n_d;
    logic                    frame_err_set;
    logic                    overrun_set;
    logic                    wd_fire;

`ifdef SIPO_RX_CTRL_TIMEOUT_EN
    localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT_CYCLES - 1);

    logic [WdW-1:0] wd_q, wd_d;

    // Counts idle SHIFT cycles only while a partial word is outstanding.
    always_comb begin
        wd_d    = '0;
        wd_fire = 1'b0;
        if (state_q == StShift && !cs_n && !bit_stb && cnt_q != '0) begin
            if (wd_q == WdLast) begin
                wd_fire = 1'b1;
            end else begin
                wd_d = wd_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end
`else
    // TIMEOUT_CYCLES is legal only from 1 up, so this is a constant 0: no watchdog.
    assign wd_fire = (TIMEOUT_CYCLES == 0);
`endif

    assign sr_sh = bit_stb & (state_q == StShift);

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        capture_pend_d = 1'b0;
        frame_err_set  = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (!cs_n) begin
                    state_d = StShift;
                end
            end
            StShift: begin
                if (bit_stb) begin
                    if (cnt_q == LastCnt) begin
                        cnt_d          = '0;
                        capture_pend_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                // A strobe coinciding with cs_n rising is counted before judging the frame.
                if (cs_n) begin
                    state_d       = StIdle;
                    frame_err_set = (cnt_d != '0);
                    cnt_d         = '0;
                end else if (wd_fire) begin
                    cnt_d         = '0;
                    frame_err_set = 1'b1;
                end
            end
        endcase
        sr_clr_n_d = (state_d == StShift) && !wd_fire;
    end

    always_comb begin
        m_data_d    = m_data_q;
        m_valid_d   = m_valid_q;
        overrun_set = 1'b0;
        if (capture_pend_q) begin
            if (!m_valid_q || m_ready) begin
                m_data_d  = sr_q;
                m_valid_d = 1'b1;
            end else begin
                overrun_set = 1'b1;
            end
        end else if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end
        overrun_d   = overrun_set | (overrun_q & ~err_clr);
        frame_err_d = frame_err_set | (frame_err_q & ~err_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            capture_pend_q <= 1'b0;
            m_data_q       <= '0;
            m_valid_q      <= 1'b0;
            overrun_q      <= 1'b0;
            frame_err_q    <= 1'b0;
            sr_clr_n_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            capture_pend_q <= capture_pend_d;
            m_data_q       <= m_data_d;
            m_valid_q      <= m_valid_d;
            overrun_q      <= overrun_d;
            frame_err_q    <= frame_err_d;
            sr_clr_n_q     <= sr_clr_n_d;
        end
    end

    assign sr_clr_n  = sr_clr_n_q;
    assign m_data    = m_data_q;
    assign m_valid   = m_valid_q;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;
    assign bit_cnt   = cnt_q;

endmodule

// File: tb/tb_sipo_rx_ctrl.sv
// Bench for sipo_rx_ctrl: directed scenarios then random frames against a word-queue model.
// Watchdog scenario follows SIPO_RX_CTRL_TIMEOUT_EN.
module tb_sipo_rx_ctrl;
    localparam int unsigned DW = 8;
    localparam int unsigned TO = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cs_n = 1'b1;
    logic          bit_stb = 1'b0;
    logic          m_ready = 1'b0;
    logic          err_clr = 1'b0;
    logic          sd = 1'b0;
    logic          sr_sh, sr_clr_n, m_valid, overrun, frame_err;
    logic [DW-1:0] sr_q, m_data;
    logic [3:0]    bit_cnt;
    logic [DW-1:0] sipo = '0;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] exp_q[$];
    bit            auto_ready = 1'b0;
    int            vhold = 0;
    logic          prev_hold = 1'b0;
    logic [DW-1:0] prev_data = '0;

    always #5 clk = ~clk;

    // Environment model of the SIPO: sync clear, MSB-first shift.
    always @(posedge clk) begin
        if (!sr_clr_n) sipo <= '0;
        else if (sr_sh) sipo <= {sipo[DW-2:0], sd};
    end
    assign sr_q = sipo;

    sipo_rx_ctrl #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cs_n      (cs_n),
        .bit_stb   (bit_stb),
        .sr_sh     (sr_sh),
        .sr_clr_n  (sr_clr_n),
        .sr_q      (sr_q),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .err_clr   (err_clr),
        .overrun   (overrun),
        .frame_err (frame_err),
        .bit_cnt   (bit_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    // Consumer side: every accepted word must be the next one the model expects.
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_hold) chk("m_data_stable", m_data, prev_data);
            if (m_valid && m_ready) begin
                chk("word_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) chk("word_data", m_data, exp_q.pop_front());
            end
            prev_hold = m_valid && !m_ready;
            prev_data = m_data;
        end else begin
            prev_hold = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (auto_ready) begin
            vhold   = m_valid ? vhold + 1 : 0;
            m_ready = (vhold >= 3) || ($urandom_range(0, 1) == 1);
        end
    endtask

    // Sends the top nbits of w MSB first; optionally raises cs_n with the final strobe.
    task automatic send_bits(input logic [31:0] w, input int nbits, input int gap_max,
                             input bit raise_on_last);
        for (int i = DW - 1; i >= int'(DW) - nbits; i--) begin
            sd      = w[i];
            bit_stb = 1'b1;
            if (raise_on_last && i == int'(DW) - nbits) cs_n = 1'b1;
            step();
            bit_stb = 1'b0;
            sd      = 1'($urandom);
            repeat ($urandom_range(0, gap_max)) step();
        end
    endtask

    task automatic pulse_err_clr();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] w;
        int            nw;
        int            tail;
        bit            late;

        // Reset values
        repeat (2) step();
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_bit_cnt", bit_cnt, 0);
        chk("rst_sr_clr_n", sr_clr_n, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_frame_err", frame_err, 0);
        rst_n = 1'b1;
        step();

        // Strobes ignored in IDLE
        bit_stb = 1'b1;
        #1;
        chk("idle_sr_sh", sr_sh, 0);
        step();
        bit_stb = 1'b0;
        chk("idle_bit_cnt", bit_cnt, 0);

        // Single word 0xA5 with latency check
        m_ready = 1'b1;
        cs_n    = 1'b0;
        step();
        chk("shift_sr_clr_n", sr_clr_n, 1);
        w = 8'hA5;
        exp_q.push_back(w);
        for (int i = DW - 1; i >= 0; i--) begin
            sd      = w[i];
            bit_stb = 1'b1;
            if (i == DW - 1) begin
                #1;
                chk("shift_sr_sh", sr_sh, 1);
            end
            step();
            if (i == DW - 3) chk("bit_cnt_3", bit_cnt, 3);
        end
        bit_stb = 1'b0;
        chk("a5_valid_e0", m_valid, 0);
        step();
        chk("a5_valid_e1", m_valid, 1);
        chk("a5_data", m_data, 8'hA5);
        step();
        chk("a5_valid_e2", m_valid, 0);
        chk("a5_overrun", overrun, 0);
        chk("a5_frame_err", frame_err, 0);
        cs_n = 1'b1;
        repeat (2) step();

        // Back-to-back words, strobe every cycle
        cs_n = 1'b0;
        step();
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'hC3);
        send_bits(32'h3C, DW, 0, 1'b0);
        send_bits(32'hC3, DW, 0, 1'b0);
        cs_n = 1'b1;
        repeat (4) step();
        chk("b2b_drained", exp_q.size(), 0);
        chk("b2b_overrun", overrun, 0);
        chk("b2b_frame_err", frame_err, 0);

        // Overrun: holder full, second word dropped
        m_ready = 1'b0;
        cs_n    = 1'b0;
        step();
        exp_q.push_back(8'h11);
        send_bits(32'h11, DW, 0, 1'b0);
        send_bits(32'h22, DW, 0, 1'b0);
        step();
        chk("ovr_flag", overrun, 1);
        chk("ovr_data", m_data, 8'h11);
        chk("ovr_valid", m_valid, 1);
        cs_n    = 1'b1;
        m_ready = 1'b1;
        step();
        chk("ovr_accepted", m_valid, 0);
        chk("ovr_sticky", overrun, 1);
        pulse_err_clr();
        chk("ovr_cleared", overrun, 0);

        // Truncated frame after 5 bits, then a good frame
        cs_n = 1'b0;
        step();
        send_bits(32'hF0, 5, 0, 1'b0);
        cs_n = 1'b1;
        step();
        chk("trunc_frame_err", frame_err, 1);
        chk("trunc_sr_clr_n", sr_clr_n, 0);
        chk("trunc_m_valid", m_valid, 0);
        chk("trunc_bit_cnt", bit_cnt, 0);
        pulse_err_clr();
        chk("trunc_cleared", frame_err, 0);
        cs_n = 1'b0;
        step();
        exp_q.push_back(8'hF0);
        send_bits(32'hF0, DW, 0, 1'b0);
        cs_n = 1'b1;
        repeat (3) step();
        chk("f0_drained", exp_q.size(), 0);

        // Asynchronous reset mid-word with a word held
        m_ready = 1'b0;
        cs_n    = 1'b0;
        step();
        send_bits(32'h5A, DW, 0, 1'b0);
        send_bits(32'hE0, 3, 0, 1'b0);
        chk("prerst_bit_cnt", bit_cnt, 3);
        chk("prerst_m_valid", m_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_bit_cnt", bit_cnt, 0);
        chk("arst_m_valid", m_valid, 0);
        chk("arst_m_data", m_data, 0);
        chk("arst_sr_clr_n", sr_clr_n, 0);
        chk("arst_sr_sh", sr_sh, 0);
        cs_n = 1'b1;
        step();
        rst_n = 1'b1;
        step();
        m_ready = 1'b1;
        cs_n    = 1'b0;
        step();
        exp_q.push_back(8'h81);
        send_bits(32'h81, DW, 0, 1'b0);
        cs_n = 1'b1;
        repeat (3) step();
        chk("x81_drained", exp_q.size(), 0);
        chk("x81_frame_err", frame_err, 0);

        // Stall after 4 strobes
        cs_n = 1'b0;
        step();
        send_bits(32'hB4, 4, 0, 1'b0);
`ifdef SIPO_RX_CTRL_TIMEOUT_EN
        repeat (TO - 1) step();
        chk("wd_before_cnt", bit_cnt, 4);
        chk("wd_before_err", frame_err, 0);
        step();
        chk("wd_fire_cnt", bit_cnt, 0);
        chk("wd_fire_err", frame_err, 1);
        chk("wd_fire_clr", sr_clr_n, 0);
        step();
        chk("wd_after_clr", sr_clr_n, 1);
        pulse_err_clr();
`else
        repeat (40) step();
        chk("stall_cnt", bit_cnt, 4);
        chk("stall_err", frame_err, 0);
        cs_n = 1'b1;
        step();
        chk("stall_end_err", frame_err, 1);
        pulse_err_clr();
        cs_n = 1'b0;
        step();
`endif
        exp_q.push_back(8'h69);
        send_bits(32'h69, DW, 0, 1'b0);
        cs_n = 1'b1;
        repeat (3) step();
        chk("stall_word", exp_q.size(), 0);

        // Random frames: words, gaps, optional truncated tail, cs_n rising on the last strobe
        auto_ready = 1'b1;
        for (int f = 0; f < 30; f++) begin
            cs_n = 1'b0;
            step();
            nw   = $urandom_range(1, 3);
            tail = ($urandom_range(0, 3) == 0) ? $urandom_range(1, DW - 1) : 0;
            late = 1'($urandom_range(0, 1));
            for (int k = 0; k < nw; k++) begin
                w = DW'($urandom);
                exp_q.push_back(w);
                send_bits(32'(w), DW, 2, (k == nw - 1) && (tail == 0) && late);
            end
            if (tail != 0) send_bits($urandom, tail, 2, late);
            cs_n = 1'b1;
            repeat (6) step();
            chk("rnd_frame_err", frame_err, (tail != 0) ? 1 : 0);
            chk("rnd_overrun", overrun, 0);
            chk("rnd_drained", exp_q.size(), 0);
            pulse_err_clr();
        end
        auto_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
